mmu_drive_sync_bridge: RTL and testbench
========================================

# mmu_drive_sync_bridge

Clocked consumer stage for one branch of the MMU click-element splitter. It accepts a two-phase (transition-signalled) drive/free token with bundled request data from the asynchronous control fabric and synchronises the drive into the clock domain. Each token's data is captured into a small FIFO, and the token is acknowledged by toggling free. Tokens are presented to the synchronous MMU pipeline on a valid/ready interface.

## Interface

Parameters:
- DATA_W, 32, width of the bundled request word (VA plus attributes)
- DEPTH, 4, FIFO entries; power of two, ≥2
- SYNC_STAGES, 2, flops in the i_drive synchroniser; ≥2

Ports:
- clk  in  1  single clock
- rstn  in  1  reset, asynchronous, active-low
- i_drive  in  1  two-phase request from the splitter branch; each transition is one token
- o_free  out  1  two-phase acknowledge to the splitter; each transition retires one token
- i_data  in  DATA_W  bundled data; stable from the i_drive transition until the matching o_free transition
- o_valid  out  1  FIFO head valid
- i_ready  in  1  downstream accepts the head when o_valid & i_ready at a rising clk edge
- o_data  out  DATA_W  FIFO head data
- o_count  out  $clog2(DEPTH+1)  current occupancy

## Operation

- Synchroniser: i_drive → SYNC_STAGES flops → drv_s. Register lvl holds the last accepted drive level.
- tok_pend = drv_s ^ lvl.
- push = tok_pend & (count < DEPTH | pop).
- pop = o_valid & i_ready.
- On push:
  - mem[wptr] ← i_data
  - wptr++ (mod DEPTH, wraps naturally)
  - lvl ← drv_s
  - o_free toggles
- On pop: rptr++ (mod DEPTH).
- count updates by +push −pop. Simultaneous push and pop leave count unchanged and are legal both when empty (see Configuration) and when full.
- Full with a token pending:
  - o_free is not toggled.
  - The upstream is held by the handshake, and i_data remains valid.
  - The push occurs on the first cycle with space.
- Two-phase protocol: at most one token is outstanding, since the upstream cannot re-toggle before o_free toggles. A second i_drive transition before o_free toggles is a protocol violation; behaviour is undefined.
- o_data = mem[rptr]. o_valid = (count != 0).

## Timing

- Reset values (asynchronous, on rstn low): sync flops 0, lvl 0, o_free 0, wptr 0, rptr 0, count 0, o_valid 0. o_data is don't-care while o_valid = 0.
- Latency: an i_drive toggle first sampled at edge E0 is pushed at edge E0+SYNC_STAGES. o_free toggles and o_valid rises after that same edge. Default is 2 cycles after first sample.
- o_free is driven directly from a flop, so it is glitch-free for the asynchronous upstream.
- Throughput into the FIFO is limited by the async round trip, not by the clock.
- Reset mid-operation: the FIFO is flushed and all state returns to reset values. The upstream shares rstn and returns i_drive to 0, so tok_pend = 0 after release.
- Consecutive edges: back-to-back pops at 1 per cycle are supported.

## Configuration

- MMU_BRIDGE_BYPASS_EN defined:
  - When count == 0, tok_pend = 1 and i_ready = 1, the token is presented combinationally with o_valid = 1 and o_data = i_data.
  - It is consumed at that edge without being written to the FIFO. lvl updates and o_free toggles.
  - Latency is reduced by one cycle for an empty FIFO with downstream ready.
  - Ordering is preserved because bypass is allowed only when the FIFO is empty.
- MMU_BRIDGE_BYPASS_EN not defined:
  - All tokens pass through the FIFO. o_valid and o_data depend only on registers.

## Test plan

- Reset then a single token: i_drive 0→1 with i_data=0x1234_5678 and i_ready=1. Required: o_free 0→1 and o_valid=1 with o_data=0x1234_5678 exactly SYNC_STAGES edges after first sample, one cycle earlier with bypass. o_count returns to 0.
- Fill: i_ready=0 and 5 tokens, each issued after the previous o_free toggle, with data 1..5. Required: 4 o_free toggles, o_count=4, and the 5th token is held with o_free unchanged. Raising i_ready drains 1,2,3,4,5 in order, and the 5th o_free toggle occurs on the first pop.
- Full with simultaneous push and pop: count=4, token pending, i_ready=1. Required: push and pop on the same edge, count stays 4, o_free toggles.
- Wrap-around: 10 tokens streamed with i_ready toggling every other cycle. Required: output sequence equals input sequence and pointers wrap mod 4.
- Reset mid-operation: count=3 and a token pending when rstn is pulsed low. Required: o_valid=0, o_count=0, o_free=0 immediately; no output after release until a new i_drive transition.

Source files
------------

// File: rtl/mmu_drive_sync_bridge_if.sv
// Bus bundle between the MMU splitter branch (two-phase drive/free + data)
// and the synchronous MMU pipeline (valid/ready + occupancy).
interface mmu_drive_sync_bridge_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  logic                       i_drive;
  logic                       o_free;
  logic [DATA_W-1:0]          i_data;
  logic                       o_valid;
  logic                       i_ready;
  logic [DATA_W-1:0]          o_data;
  logic [$clog2(DEPTH+1)-1:0] o_count;

  modport slave (
    input  i_drive, i_data, i_ready,
    output o_free, o_valid, o_data, o_count
  );

  modport master (
    output i_drive, i_data, i_ready,
    input  o_free, o_valid, o_data, o_count
  );
endinterface

// File: rtl/mmu_drive_sync_bridge.sv
// Two-phase drive/free consumer: synchronises i_drive, captures i_data into a FIFO
// and acks by toggling o_free. Define MMU_BRIDGE_BYPASS_EN for empty-FIFO bypass.
module mmu_drive_sync_bridge #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  mmu_drive_sync_bridge_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [SYNC_STAGES-1:0] syncReg;
  logic [SYNC_STAGES-1:0] syncNext;
  logic                   drvS;
  logic                   lvlReg;
  logic                   freeReg;
  logic [PTR_W-1:0]       wPtrReg;
  logic [PTR_W-1:0]       rPtrReg;
  logic [CNT_W-1:0]       countReg;
  logic [CNT_W-1:0]       countNext;
  logic [DATA_W-1:0]      mem [DEPTH];

  logic tokPend;
  logic fifoValid;
  logic fifoPop;
  logic accept;
  logic fifoPush;
  logic bypass;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign syncNext[gi] = bus.i_drive;
      end else begin : g_chain
        assign syncNext[gi] = syncReg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      syncReg <= '0;
    end else begin
      syncReg <= syncNext;
    end
  end

  assign drvS      = syncReg[SYNC_STAGES-1];
  assign tokPend   = drvS ^ lvlReg;
  assign fifoValid = (countReg != '0);
  assign fifoPop   = fifoValid & bus.i_ready;

`ifdef MMU_BRIDGE_BYPASS_EN
  // Only when empty, so a bypassed token can never overtake a stored one.
  assign bypass      = ~fifoValid & tokPend & bus.i_ready;
  assign bus.o_valid = fifoValid | bypass;
  assign bus.o_data  = bypass ? bus.i_data : mem[rPtrReg];
`else
  assign bypass      = 1'b0;
  assign bus.o_valid = fifoValid;
  assign bus.o_data  = mem[rPtrReg];
`endif

  // A full FIFO still accepts when the head leaves on the same edge.
  assign accept   = tokPend & ((countReg < CNT_W'(DEPTH)) | fifoPop);
  assign fifoPush = accept & ~bypass;

  always_comb begin
    countNext = countReg;
    case ({fifoPush, fifoPop})
      2'b10:   countNext = countReg + CNT_W'(1);
      2'b01:   countNext = countReg - CNT_W'(1);
      default: countNext = countReg;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lvlReg   <= 1'b0;
      freeReg  <= 1'b0;
      wPtrReg  <= '0;
      rPtrReg  <= '0;
      countReg <= '0;
    end else begin
      if (accept) begin
        lvlReg  <= drvS;
        freeReg <= ~freeReg;
      end
      if (fifoPush) begin
        wPtrReg <= wPtrReg + PTR_W'(1);
      end
      if (fifoPop) begin
        rPtrReg <= rPtrReg + PTR_W'(1);
      end
      countReg <= countNext;
    end
  end

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (fifoPush) begin
      mem[wPtrReg] <= bus.i_data;
    end
  end

  assign bus.o_free  = freeReg;
  assign bus.o_count = countReg;

endmodule

// File: tb/tb_mmu_drive_sync_bridge.sv
// Directed bench for mmu_drive_sync_bridge: reset, single token latency, fill/hold,
// full push+pop, wrap-around streaming and reset mid-operation.
module tb_mmu_drive_sync_bridge;

  localparam int DATA_W      = 32;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  mmu_drive_sync_bridge_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  mmu_drive_sync_bridge #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus.slave)
  );

  int passCnt = 0;
  int totalCnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int recv;
    logic [31:0] expQ[$];

    bus.i_drive = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_count", 32'(bus.o_count), 0);
    chk("rst_free",  32'(bus.o_free),  0);
    rstn = 1'b1;
    tick();

    // Single token, downstream ready
    bus.i_data  = 32'h1234_5678;
    bus.i_drive = 1'b1;
    bus.i_ready = 1'b1;
    tick();
    chk("t1_e0_free",  32'(bus.o_free),  0);
    chk("t1_e0_valid", 32'(bus.o_valid), 0);
    tick();
    chk("t1_e1_free", 32'(bus.o_free), 0);
`ifdef MMU_BRIDGE_BYPASS_EN
    chk("t1_e1_valid", 32'(bus.o_valid), 1);
    chk("t1_e1_data",  bus.o_data, 32'h1234_5678);
    tick();
    chk("t1_e2_free",  32'(bus.o_free),  1);
    chk("t1_e2_valid", 32'(bus.o_valid), 0);
    chk("t1_e2_count", 32'(bus.o_count), 0);
`else
    chk("t1_e1_valid", 32'(bus.o_valid), 0);
    tick();
    chk("t1_e2_free",  32'(bus.o_free),  1);
    chk("t1_e2_valid", 32'(bus.o_valid), 1);
    chk("t1_e2_data",  bus.o_data, 32'h1234_5678);
    chk("t1_e2_count", 32'(bus.o_count), 1);
    tick();
    chk("t1_e3_valid", 32'(bus.o_valid), 0);
    chk("t1_e3_count", 32'(bus.o_count), 0);
`endif

    // Fill four entries with downstream stalled
    bus.i_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      bus.i_data  = 32'(k);
      bus.i_drive = ~bus.i_drive;
      tick();
      tick();
      chk($sformatf("fill%0d_not_yet", k), 32'(bus.o_free ^ bus.i_drive), 1);
      tick();
      chk($sformatf("fill%0d_ack", k),   32'(bus.o_free ^ bus.i_drive), 0);
      chk($sformatf("fill%0d_count", k), 32'(bus.o_count), 32'(k));
    end

    // Fifth token must be held while full
    bus.i_data  = 32'd5;
    bus.i_drive = ~bus.i_drive;
    repeat (6) tick();
    chk("full_held",  32'(bus.o_free ^ bus.i_drive), 1);
    chk("full_count", 32'(bus.o_count), 4);
    chk("full_valid", 32'(bus.o_valid), 1);
    chk("full_head",  bus.o_data, 1);

    // Drain; first edge is a simultaneous push and pop at full
    bus.i_ready = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      chk($sformatf("drain%0d_valid", e), 32'(bus.o_valid), 1);
      chk($sformatf("drain%0d_data", e),  bus.o_data, 32'(e));
      tick();
      if (e == 1) begin
        chk("pushpop_ack",   32'(bus.o_free ^ bus.i_drive), 0);
        chk("pushpop_count", 32'(bus.o_count), 4);
      end
    end
    chk("drain_valid", 32'(bus.o_valid), 0);
    chk("drain_count", 32'(bus.o_count), 0);

    // Wrap-around stream with i_ready toggling
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
      if (sent < 10 && bus.o_free == bus.i_drive) begin
        bus.i_data = 32'hC0DE_0000 + 32'(sent);
        expQ.push_back(bus.i_data);
        bus.i_drive = ~bus.i_drive;
        sent++;
      end
      bus.i_ready = ((cyc % 2) == 1);
      #1;
      if (bus.o_valid && bus.i_ready) begin
        chk($sformatf("wrap%0d_data", recv), bus.o_data, expQ[recv]);
        recv++;
      end
      tick();
    end
    chk("wrap_recv",  32'(recv), 10);
    chk("wrap_count", 32'(bus.o_count), 0);

    // Reset with three entries stored and a token pending
    bus.i_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus.i_data  = 32'h50 + 32'(k);
      bus.i_drive = ~bus.i_drive;
      repeat (3) tick();
    end
    chk("mid_count", 32'(bus.o_count), 3);
    bus.i_data  = 32'h99;
    bus.i_drive = ~bus.i_drive;
    tick();
    tick();
    chk("mid_pending", 32'(bus.o_free ^ bus.i_drive), 1);
    chk("mid_free_pre", 32'(bus.o_free), 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.o_valid), 0);
    chk("mid_rst_count", 32'(bus.o_count), 0);
    chk("mid_rst_free",  32'(bus.o_free),  0);
    bus.i_drive = 1'b0;
    bus.i_ready = 1'b1;
    repeat (2) tick();
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("post_rst%0d_valid", c), 32'(bus.o_valid), 0);
    end
    chk("post_rst_free", 32'(bus.o_free), 0);

    // Fresh token after reset
    bus.i_ready = 1'b0;
    bus.i_data  = 32'hBEEF;
    bus.i_drive = 1'b1;
    repeat (3) tick();
    chk("rec_free",  32'(bus.o_free),  1);
    chk("rec_valid", 32'(bus.o_valid), 1);
    chk("rec_data",  bus.o_data, 32'hBEEF);
    chk("rec_count", 32'(bus.o_count), 1);
    bus.i_ready = 1'b1;
    tick();
    chk("rec_drained", 32'(bus.o_count), 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
